// File: rtl/eic_ahb_regs.sv
`default_nettype none
// ============================================================================
// Module   : eic_ahb_regs
// Brief    : AHB-Lite register file in front of the external interrupt
//            controller core: mask, sense-mode configuration, forced flag
//            writes (set/clear/load) and pending-request readback.
// Revision : 1.0 - initial release
// ============================================================================
module eic_ahb_regs #(
    parameter int EIC_DIRECT_CHANNELS = 32,
    parameter int EIC_SENSE_CHANNELS  = 32,
    parameter int EIC_TOTAL_CHANNELS  = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
    input  logic                            CLK,
    input  logic                            RESETn,
    input  logic                            HSEL,
    input  logic [31:0]                     HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [31:0]                     HWDATA,
    input  logic                            HREADY,
    output logic [31:0]                     HRDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    input  logic [EIC_TOTAL_CHANNELS-1:0]   request,
    output logic [EIC_TOTAL_CHANNELS-1:0]   mask,
    output logic [2*EIC_SENSE_CHANNELS-1:0] senceMask,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestWR,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestIn
);

    // Implemented-channel masks; bits above the channel count stay 0.
    localparam logic [63:0] C_CH_VALID    = (64'd1 << EIC_TOTAL_CHANNELS) - 64'd1;
    localparam logic [63:0] C_SENSE_VALID = (64'd1 << (2 * EIC_SENSE_CHANNELS)) - 64'd1;

    // Word offsets (HADDR[5:2])
    localparam logic [3:0] c_EICR     = 4'h0;
    localparam logic [3:0] c_EIMSK_L  = 4'h1;
    localparam logic [3:0] c_EIMSK_H  = 4'h2;
    localparam logic [3:0] c_EIFR_L   = 4'h3;
    localparam logic [3:0] c_EIFR_H   = 4'h4;
    localparam logic [3:0] c_EIFRS_L  = 4'h5;
    localparam logic [3:0] c_EIFRS_H  = 4'h6;
    localparam logic [3:0] c_EIFRC_L  = 4'h7;
    localparam logic [3:0] c_EIFRC_H  = 4'h8;
    localparam logic [3:0] c_EISMSK_L = 4'h9;
    localparam logic [3:0] c_EISMSK_H = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  addr_q;
    logic        write_q;
    logic        size_ok_q;
    logic [31:0] eicr_q, eicr_d;
    logic [63:0] mask_q, mask_d;
    logic [63:0] smask_q, smask_d;

    logic        w_accept;
    logic        w_wr_phase;
    logic [63:0] w_req;
    logic [63:0] w_rwr;
    logic [63:0] w_rin;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_accept   = HSEL & HREADY & HTRANS[1];
    assign w_wr_phase = (state_q == S_WR) & write_q & size_ok_q;

    // Address bits outside the decoded window and HTRANS[0] carry no meaning here.
    assign w_unused = ^{HADDR[31:6], HADDR[1:0], HTRANS[0]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Next data-phase state: a new accepted address phase always wins; sub-word writes are dropped.
    always_comb begin
        state_d = S_IDLE;
        if (w_accept) begin
            if (!HWRITE) begin
                state_d = S_RD;
            end else if (HSIZE == 3'b010) begin
                state_d = S_WR;
            end
        end
    end

    // State register and address-phase capture.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= 4'h0;
            write_q   <= 1'b0;
            size_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                addr_q    <= HADDR[5:2];
                write_q   <= HWRITE;
                size_ok_q <= (HSIZE == 3'b010);
            end
        end
    end

    // Storage register next-state from the write data phase.
    always_comb begin
        eicr_d  = eicr_q;
        mask_d  = mask_q;
        smask_d = smask_q;
        if (w_wr_phase) begin
            case (addr_q)
                c_EICR:     eicr_d         = HWDATA;
                c_EIMSK_L:  mask_d[31:0]   = HWDATA & C_CH_VALID[31:0];
                c_EIMSK_H:  mask_d[63:32]  = HWDATA & C_CH_VALID[63:32];
                c_EISMSK_L: smask_d[31:0]  = HWDATA & C_SENSE_VALID[31:0];
                c_EISMSK_H: smask_d[63:32] = HWDATA & C_SENSE_VALID[63:32];
                default: ;
            endcase
        end
    end

    // Storage registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            eicr_q  <= 32'h0;
            mask_q  <= 64'h0;
            smask_q <= 64'h0;
        end else begin
            eicr_q  <= eicr_d;
            mask_q  <= mask_d;
            smask_q <= smask_d;
        end
    end

    // Zero-extend the core's request vector to the 64-bit register view.
    always_comb begin
        w_req = 64'h0;
        w_req[EIC_TOTAL_CHANNELS-1:0] = request;
    end

    // Forced flag strobes, live only while the write data phase is on the bus.
    always_comb begin
        w_rwr = 64'h0;
        w_rin = 64'h0;
        if (w_wr_phase) begin
            case (addr_q)
                c_EIFR_L:  begin w_rwr[31:0]  = 32'hFFFF_FFFF; w_rin[31:0]  = HWDATA;        end
                c_EIFR_H:  begin w_rwr[63:32] = 32'hFFFF_FFFF; w_rin[63:32] = HWDATA;        end
                c_EIFRS_L: begin w_rwr[31:0]  = HWDATA;        w_rin[31:0]  = 32'hFFFF_FFFF; end
                c_EIFRS_H: begin w_rwr[63:32] = HWDATA;        w_rin[63:32] = 32'hFFFF_FFFF; end
                c_EIFRC_L: begin w_rwr[31:0]  = HWDATA;        w_rin[31:0]  = 32'h0;         end
                c_EIFRC_H: begin w_rwr[63:32] = HWDATA;        w_rin[63:32] = 32'h0;         end
                default: ;
            endcase
        end
        w_rwr = w_rwr & C_CH_VALID;
        w_rin = w_rin & C_CH_VALID;
    end

    // Read mux, driven only during the read data phase.
    always_comb begin
        w_rdata = 32'h0;
        if (state_q == S_RD) begin
            case (addr_q)
                c_EICR:     w_rdata = eicr_q;
                c_EIMSK_L:  w_rdata = mask_q[31:0];
                c_EIMSK_H:  w_rdata = mask_q[63:32];
                c_EIFR_L:   w_rdata = w_req[31:0];
                c_EIFR_H:   w_rdata = w_req[63:32];
                c_EISMSK_L: w_rdata = smask_q[31:0];
                c_EISMSK_H: w_rdata = smask_q[63:32];
                default:    w_rdata = 32'h0;
            endcase
        end
    end

    assign HRDATA    = w_rdata;
    assign mask      = mask_q[EIC_TOTAL_CHANNELS-1:0];
    assign senceMask = smask_q[2*EIC_SENSE_CHANNELS-1:0];
    assign requestWR = w_rwr[EIC_TOTAL_CHANNELS-1:0];
    assign requestIn = w_rin[EIC_TOTAL_CHANNELS-1:0];

endmodule
`default_nettype wire

// File: tb/tb_eic_ahb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_eic_ahb_regs
// Brief    : Directed self-checking bench for eic_ahb_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eic_ahb_regs;

    logic        CLK;
    logic        RESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] request;
    logic [63:0] mask;
    logic [63:0] senceMask;
    logic [63:0] requestWR;
    logic [63:0] requestIn;

    int checks;
    int failures;

    eic_ahb_regs #(
        .EIC_DIRECT_CHANNELS(32),
        .EIC_SENSE_CHANNELS (32)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP),
        .request  (request),
        .mask     (mask),
        .senceMask(senceMask),
        .requestWR(requestWR),
        .requestIn(requestIn)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic addr_ph(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = a;
        HSIZE  = sz;
    endtask

    task automatic idle_ph();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
        HSIZE  = 3'b010;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESETn   = 1'b0;
        HREADY   = 1'b1;
        HWDATA   = 32'h0;
        request  = 64'h0;
        idle_ph();

        // Reset state
        tick();
        tick();
        chk("rst_mask", mask, 64'h0);
        chk("rst_smask", senceMask, 64'h0);
        chk("rst_hrdata", {32'h0, HRDATA}, 64'h0);
        chk("rst_reqwr", requestWR, 64'h0);
        chk("rst_hready_resp", {62'h0, HREADYOUT, HRESP}, 64'h2);
        RESETn = 1'b1;
        tick();

        // Reset asserted in the middle of a write data phase to EIMSK_L
        addr_ph(1'b1, 32'h04, 3'b010);
        tick();
        idle_ph();
        HWDATA = 32'hFFFF_FFFF;
        #1;
        RESETn = 1'b0;
        #1;
        chk("midrst_hrdata", {32'h0, HRDATA}, 64'h0);
        chk("midrst_reqwr", requestWR, 64'h0);
        tick();
        chk("midrst_mask", mask, 64'h0);
        RESETn = 1'b1;
        tick();

        // Write EIMSK_L then read it back-to-back
        addr_ph(1'b1, 32'h04, 3'b010);
        tick();
        HWDATA = 32'h0000_00A5;
        addr_ph(1'b0, 32'h04, 3'b010);
        tick();
        idle_ph();
        #1;
        chk("wr_mask", mask, 64'h0000_0000_0000_00A5);
        chk("rd_mask_l", {32'h0, HRDATA}, 64'hA5);
        tick();
        chk("rd_after_idle", {32'h0, HRDATA}, 64'h0);

        // EICR write and readback
        addr_ph(1'b1, 32'h00, 3'b010);
        tick();
        HWDATA = 32'hDEAD_BEEF;
        addr_ph(1'b0, 32'h00, 3'b010);
        tick();
        idle_ph();
        #1;
        chk("rd_eicr", {32'h0, HRDATA}, 64'hDEAD_BEEF);
        tick();

        // Set write to EIFRS_L
        addr_ph(1'b1, 32'h14, 3'b010);
        tick();
        HWDATA = 32'h0000_0011;
        idle_ph();
        #1;
        chk("set_reqwr", requestWR, 64'h0000_0000_0000_0011);
        chk("set_reqin", requestIn, 64'h0000_0000_FFFF_FFFF);
        tick();
        chk("set_reqwr_gone", requestWR, 64'h0);
        request = 64'h1234_5678_0000_0011;
        addr_ph(1'b0, 32'h0C, 3'b010);
        tick();
        addr_ph(1'b0, 32'h10, 3'b010);
        #1;
        chk("rd_eifr_l", {32'h0, HRDATA}, 64'h11);
        tick();
        idle_ph();
        #1;
        chk("rd_eifr_h", {32'h0, HRDATA}, 64'h1234_5678);
        tick();

        // Set-register read returns 0
        addr_ph(1'b0, 32'h14, 3'b010);
        tick();
        idle_ph();
        #1;
        chk("rd_eifrs", {32'h0, HRDATA}, 64'h0);
        tick();

        // Clear write to EIFRC_L followed by a load write to EIFR_L
        addr_ph(1'b1, 32'h1C, 3'b010);
        tick();
        HWDATA = 32'h0000_0001;
        addr_ph(1'b1, 32'h0C, 3'b010);
        #1;
        chk("clr_reqwr", requestWR, 64'h1);
        chk("clr_reqin", requestIn, 64'h0);
        tick();
        HWDATA = 32'h0000_0005;
        idle_ph();
        #1;
        chk("load_reqwr", requestWR, 64'h0000_0000_FFFF_FFFF);
        chk("load_reqin", requestIn, 64'h0000_0000_0000_0005);
        tick();
        chk("load_reqwr_gone", requestWR, 64'h0);

        // High-half set write
        addr_ph(1'b1, 32'h18, 3'b010);
        tick();
        HWDATA = 32'h8000_0000;
        idle_ph();
        #1;
        chk("seth_reqwr", requestWR, 64'h8000_0000_0000_0000);
        chk("seth_reqin", requestIn, 64'hFFFF_FFFF_0000_0000);
        tick();

        // Byte-size write to EISMSK_H is discarded
        addr_ph(1'b1, 32'h28, 3'b000);
        tick();
        HWDATA = 32'hC000_0000;
        idle_ph();
        #1;
        chk("bsize_reqwr", requestWR, 64'h0);
        tick();
        chk("bsize_smask", senceMask, 64'h0);

        // Word-size write to EISMSK_H takes effect and reads back
        addr_ph(1'b1, 32'h28, 3'b010);
        tick();
        HWDATA = 32'hC000_0000;
        addr_ph(1'b0, 32'h28, 3'b010);
        tick();
        idle_ph();
        #1;
        chk("wsize_smask", senceMask, 64'hC000_0000_0000_0000);
        chk("rd_smask_h", {32'h0, HRDATA}, 64'hC000_0000);
        tick();

        // Write to an unmapped offset changes nothing
        addr_ph(1'b1, 32'h30, 3'b010);
        tick();
        HWDATA = 32'hFFFF_FFFF;
        idle_ph();
        #1;
        chk("unmapped_reqwr", requestWR, 64'h0);
        tick();
        chk("unmapped_mask", mask, 64'h0000_0000_0000_00A5);

        // Read of an unmapped offset
        addr_ph(1'b0, 32'h3C, 3'b010);
        tick();
        idle_ph();
        #1;
        chk("rd_unmapped", {32'h0, HRDATA}, 64'h0);
        chk("rd_unmapped_resp", {62'h0, HREADYOUT, HRESP}, 64'h2);
        tick();

        // Read attempt with HSEL low is not accepted
        addr_ph(1'b0, 32'h04, 3'b010);
        HSEL = 1'b0;
        tick();
        idle_ph();
        #1;
        chk("rd_nosel", {32'h0, HRDATA}, 64'h0);
        chk("rd_nosel_resp", {62'h0, HREADYOUT, HRESP}, 64'h2);
        tick();

        // HTRANS=BUSY is not accepted either
        addr_ph(1'b0, 32'h04, 3'b010);
        HTRANS = 2'b01;
        tick();
        idle_ph();
        #1;
        chk("rd_busy", {32'h0, HRDATA}, 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eic_ahb_regs.md
Name: eic_ahb_regs

Overview:
AHB-Lite slave register file that sits directly upstream of the external interrupt controller core. It drives the core's per-channel mask, sense-mode configuration and forced request writes (requestWR/requestIn). It also reads back the core's pending-request vector, so software can configure, poll, set and clear interrupts over the MIPSfpga+ AHB-Lite bus.

Parameters:
EIC_DIRECT_CHANNELS, 32, channels without sense logic (legal 0..32)
EIC_SENSE_CHANNELS, 32, channels with sense logic (legal 0..32)
EIC_TOTAL_CHANNELS, EIC_DIRECT_CHANNELS+EIC_SENSE_CHANNELS, total channels; sense channels occupy the low indices

Ports:
CLK  in  1  clock; all state updates on its rising edge
RESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select
HADDR  in  32  byte address; only HADDR[5:2] decoded
HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is an active transfer
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready
HRDATA  out  32  read data (data phase)
HREADYOUT  out  1  constant 1 (zero wait state)
HRESP  out  1  constant 0 (OKAY)
request  in  EIC_TOTAL_CHANNELS  pending flags from the controller core
mask  out  EIC_TOTAL_CHANNELS  channel enable (1=enabled)
senceMask  out  2*EIC_SENSE_CHANNELS  2 bits per sense channel: 00 low, 01 any, 10 fall, 11 rise
requestWR  out  EIC_TOTAL_CHANNELS  per-bit forced-write strobe, 1 cycle
requestIn  out  EIC_TOTAL_CHANNELS  forced flag value, qualified by requestWR

Behaviour:
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On that edge, capture HADDR[5:2], HWRITE and the size_ok flag (HSIZE==3'b010) into data-phase registers.
- Data-phase state machine:
  - IDLE -> WR when an accepted write has size_ok=1.
  - IDLE -> RD when an accepted read is taken.
  - Accepted writes with HSIZE≠word are discarded and leave the machine in IDLE.
  - From WR or RD, the next state is again set by whether a new address phase is accepted that cycle (back-to-back transfers supported), else IDLE.
- Register map (byte offset, all 32-bit; bits above the channel count read 0, writes to them are ignored):
  - 0x00 EICR: general control/status, R/W.
  - 0x04 EIMSK_L: mask[31:0], R/W.
  - 0x08 EIMSK_H: mask[63:32], R/W.
  - 0x0C EIFR_L: read request[31:0]; write forces flags: requestWR[31:0]=all 1, requestIn[31:0]=HWDATA.
  - 0x10 EIFR_H: same as EIFR_L for channels 63:32.
  - 0x14 EIFRS_L, 0x18 EIFRS_H: write-1-to-set; requestWR=HWDATA, requestIn=all 1; read returns 0.
  - 0x1C EIFRC_L, 0x20 EIFRC_H: write-1-to-clear; requestWR=HWDATA, requestIn=all 0; read returns 0.
  - 0x24 EISMSK_L: senceMask[31:0] (sense channels 0-15), R/W.
  - 0x28 EISMSK_H: senceMask[63:32] (sense channels 16-31), R/W.
  - Any other offset reads 0; writes to it are ignored.
- Storage registers (EICR, EIMSK, EISMSK) update on the clock edge that ends the write data phase, using HWDATA sampled at that edge.
- requestWR/requestIn timing:
  - Both are combinational from the WR state, the captured address and HWDATA.
  - They are valid only during the write data-phase cycle and are all-zero otherwise.
  - The core's flag flops therefore take the new value on the same edge as a storage register would.
- Read timing:
  - HRDATA is combinational from the captured address during the RD data phase and is 0 outside RD.
  - EIFR reads return the live request input.
- Write then read of the same address back-to-back returns the newly written value.
- A set or clear write is followed in the next data phase by the updated flag, per core timing.
- Reset (RESETn=0, asynchronous):
  - State goes to IDLE.
  - Captured address and write flag clear.
  - EICR, mask and senceMask go to 0.
  - requestWR, requestIn and HRDATA go to 0.
  - A transfer in flight is dropped and no register is written.
- Deassertion takes effect on the first CLK edge with RESETn=1.
- HSEL=0 or HTRANS=IDLE/BUSY during an address phase: no capture; the machine returns to IDLE after any current data phase.

Test Plan:
- Reset asserted mid write data phase to 0x04 with HWDATA=0xFFFF_FFFF -> mask stays 0; HRDATA=0; requestWR=0.
- Write 0x04=0x0000_00A5, then read 0x04 back-to-back -> mask[31:0]=0xA5 after the write edge; read data phase HRDATA=0x0000_00A5.
- Write 0x14 (EIFRS_L)=0x0000_0011 -> exactly one cycle with requestWR[31:0]=0x11 and requestIn[31:0]=0xFFFF_FFFF; with request driven to 0x11, a read of 0x0C returns 0x11.
- Write 0x1C (EIFRC_L)=0x0000_0001 -> single-cycle requestWR[0]=1, requestIn[0]=0; a write to 0x0C=0x5 gives requestWR[31:0]=all 1, requestIn=0x5.
- Write 0x28=0xC000_0000 with HSIZE=3'b000 -> senceMask unchanged; same write with HSIZE=3'b010 -> senceMask[63:62]=2'b11 (channel 31 rising edge).
- Read 0x3C, and read with HSEL=0 -> HRDATA=0, HREADYOUT=1, HRESP=0 throughout.
